// File: rtl/flash_cal_pkg.sv
// Shared constants and types for the flash ADC calibration trim loader.
// Holds the bus geometry, the loader FSM states and the sign-magnitude trim word.
package flash_cal_pkg;

  localparam int NUM_CMP    = 32;
  localparam int CAL_BYTE_W = 8;
  localparam int TRIM_BITS  = 5;
  localparam int HALF_W     = 128;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  typedef struct packed {
    logic       sign;
    logic [3:0] mag;
  } trim_word_t;

endpackage

// File: rtl/flash_cal_byte_decode.sv
// Combinational decode of one calibration offset byte into a sign-magnitude trim word.
// A byte with both nibbles non-zero is invalid and decodes to +0.
module flash_cal_byte_decode
  import flash_cal_pkg::*;
(
  input  logic [CAL_BYTE_W-1:0] cal_byte,
  output trim_word_t            word,
  output logic                  invalid
);

  logic [3:0] hi_s;
  logic [3:0] lo_s;

  assign hi_s = cal_byte[7:4];
  assign lo_s = cal_byte[3:0];

  // Upper nibble is a positive offset, lower nibble a negative one.
  always_comb begin
    word    = '0;
    invalid = 1'b0;
    case ({hi_s != 4'd0, lo_s != 4'd0})
      2'b00: begin
        word.sign = 1'b0;
        word.mag  = 4'd0;
      end
      2'b10: begin
        word.sign = 1'b0;
        word.mag  = hi_s;
      end
      2'b01: begin
        word.sign = 1'b1;
        word.mag  = lo_s;
      end
      2'b11: begin
        word.sign = 1'b0;
        word.mag  = 4'd0;
        invalid   = 1'b1;
      end
      default: begin
        word    = '0;
        invalid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/flash_cal_trim_loader.sv
// Snapshots the comparator calibration bus on a ready rising edge and shifts the
// decoded trim words, comparator LAST down to FIRST, into the analog trim chain.
module flash_cal_trim_loader #(
  parameter int FIRST     = 16,
  parameter int LAST      = 31,
  parameter int TRIM_BITS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [flash_cal_pkg::HALF_W-1:0] cal_bot,
  input  logic [flash_cal_pkg::HALF_W-1:0] cal_top,
  output logic                          trim_sclk_en,
  output logic                          trim_sdata,
  output logic                          trim_latch,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [5:0]                    err_cnt
);

  import flash_cal_pkg::*;

  if (TRIM_BITS != flash_cal_pkg::TRIM_BITS || FIRST < 0 || LAST > NUM_CMP - 1 || FIRST > LAST) begin : g_bad_params
    $error("flash_cal_trim_loader: illegal parameter set");
  end

  state_t              state_r, state_nx;
  logic                start_d_r;
  logic                req_s;
  logic [2*HALF_W-1:0] snap_r;
  logic [2*HALF_W-1:0] bus_s;
  logic [4:0]          cmp_idx_r, cmp_nx, cmp_sel_s;
  logic [2:0]          bit_idx_r, bit_nx, bit_sel_s;
  logic [7:0]          cur_byte_s;
  trim_word_t          word_s;
  logic [4:0]          word_vec_s;
  logic                invalid_s;
  logic                word_bit_s;
  logic                emit_s;
  logic                sclk_nx, sdata_nx, latch_nx, busy_nx, done_nx;
  logic [5:0]          err_cnt_nx;

  assign req_s = start & ~start_d_r;

  // The first bit leaves at the capture edge, so it must come from the live bus.
  assign bus_s      = (state_r == ST_CAPTURE) ? {cal_top, cal_bot} : snap_r;
  assign cur_byte_s = bus_s[{cmp_sel_s, 3'b000} +: 8];
  assign word_vec_s = word_s;
  assign word_bit_s = word_vec_s[bit_sel_s];

  flash_cal_byte_decode u_decode (
    .cal_byte (cur_byte_s),
    .word     (word_s),
    .invalid  (invalid_s)
  );

  // Selects the chain position to be presented after the coming edge.
  always_comb begin
    if (state_r == ST_CAPTURE) begin
      cmp_sel_s = 5'(LAST);
      bit_sel_s = 3'd4;
    end else if (bit_idx_r == 3'd0) begin
      cmp_sel_s = cmp_idx_r - 5'd1;
      bit_sel_s = 3'd4;
    end else begin
      cmp_sel_s = cmp_idx_r;
      bit_sel_s = bit_idx_r - 3'd1;
    end
  end

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_nx   = state_r;
    cmp_nx     = cmp_idx_r;
    bit_nx     = bit_idx_r;
    busy_nx    = busy;
    done_nx    = done;
    latch_nx   = 1'b0;
    emit_s     = 1'b0;
    err_cnt_nx = err_cnt;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (req_s) begin
          state_nx   = ST_CAPTURE;
          busy_nx    = 1'b1;
          done_nx    = 1'b0;
          err_cnt_nx = 6'd0;
        end else begin
          state_nx = state_r;
        end
      end
      ST_CAPTURE: begin
        state_nx = ST_SHIFT;
        cmp_nx   = cmp_sel_s;
        bit_nx   = bit_sel_s;
        emit_s   = 1'b1;
      end
      ST_SHIFT: begin
        if (cmp_idx_r == 5'(FIRST) && bit_idx_r == 3'd0) begin
          state_nx = ST_LATCH;
          latch_nx = 1'b1;
        end else begin
          cmp_nx = cmp_sel_s;
          bit_nx = bit_sel_s;
          emit_s = 1'b1;
        end
      end
      ST_LATCH: begin
        state_nx = ST_DONE;
        busy_nx  = 1'b0;
        done_nx  = 1'b1;
      end
      default: begin
        state_nx = ST_IDLE;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
      end
    endcase
    if (emit_s) begin
      sclk_nx  = 1'b1;
      sdata_nx = word_bit_s;
      if (bit_sel_s == 3'd4 && invalid_s) begin
        err_cnt_nx = err_cnt + 6'd1;
      end else begin
        err_cnt_nx = err_cnt_nx;
      end
    end else begin
      sclk_nx  = 1'b0;
      sdata_nx = 1'b0;
    end
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      start_d_r    <= 1'b0;
      cmp_idx_r    <= 5'd0;
      bit_idx_r    <= 3'd0;
      trim_sclk_en <= 1'b0;
      trim_sdata   <= 1'b0;
      trim_latch   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_cnt      <= 6'd0;
    end else begin
      state_r      <= state_nx;
      start_d_r    <= start;
      cmp_idx_r    <= cmp_nx;
      bit_idx_r    <= bit_nx;
      trim_sclk_en <= sclk_nx;
      trim_sdata   <= sdata_nx;
      trim_latch   <= latch_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      err          <= (err_cnt_nx != 6'd0);
      err_cnt      <= err_cnt_nx;
    end
  end

  // Calibration snapshot, frozen for the rest of the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_r <= '0;
    end else if (state_r == ST_CAPTURE) begin
      snap_r <= {cal_top, cal_bot};
    end else begin
      snap_r <= snap_r;
    end
  end

endmodule

// File: tb/tb_flash_cal_trim_loader.sv
// Self-checking bench: a default 16-comparator loader and a single-comparator loader
// are compared every cycle against a model built from the decode and timing rules.
module tb_flash_cal_trim_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start0 = 1'b0;
  logic         start1 = 1'b0;
  logic [7:0]   cal_b [32];
  logic [127:0] cal_bot, cal_top;

  logic         sclk0, sdata0, latch0, busy0, done0, err0;
  logic [5:0]   cnt0;
  logic         sclk1, sdata1, latch1, busy1, done1, err1;
  logic [5:0]   cnt1;
  logic [11:0]  obs0, obs1;

  int           checks = 0;
  int           errors = 0;
  bit           obs_bits [$];
  logic [5:0]   last_cnt;
  logic         last_err;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 16; i++) begin : g_bus
    assign cal_bot[8*i +: 8] = cal_b[i];
    assign cal_top[8*i +: 8] = cal_b[16+i];
  end

  assign obs0 = {busy0, sclk0, sdata0, latch0, done0, err0, cnt0};
  assign obs1 = {busy1, sclk1, sdata1, latch1, done1, err1, cnt1};

  flash_cal_trim_loader dut (
    .clk(clk), .rst(rst), .start(start0), .cal_bot(cal_bot), .cal_top(cal_top),
    .trim_sclk_en(sclk0), .trim_sdata(sdata0), .trim_latch(latch0),
    .busy(busy0), .done(done0), .err(err0), .err_cnt(cnt0)
  );

  flash_cal_trim_loader #(.FIRST(31), .LAST(31), .TRIM_BITS(5)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cal_bot(cal_bot), .cal_top(cal_top),
    .trim_sclk_en(sclk1), .trim_sdata(sdata1), .trim_latch(latch1),
    .busy(busy1), .done(done1), .err(err1), .err_cnt(cnt1)
  );

  function automatic logic [7:0] rnd_byte();
    logic [3:0] h = 4'($urandom_range(1, 15));
    logic [3:0] l = 4'($urandom_range(1, 15));
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return {h, 4'h0};
      2:       return {4'h0, l};
      default: return {h, l};
    endcase
  endfunction

  function automatic logic [4:0] slot(input int base);
    logic [4:0] v = 5'd0;
    for (int i = 0; i < 5; i++) v = {v[3:0], logic'(obs_bits[base+i])};
    return v;
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  task automatic load(input string tag, input bit sel, input int first, input int last,
                      input bit toggle_mid, input bit change_mid);
    bit          exp_bits [$];
    int          exp_cnt [$];
    int          run = 0;
    int          n = last - first + 1;
    logic [11:0] obs, exp;
    logic        e_busy, e_sclk, e_sdata, e_latch, e_done;
    int          e_cnt;
    for (int c = last; c >= first; c--) begin
      logic [3:0] hi = cal_b[c][7:4];
      logic [3:0] lo = cal_b[c][3:0];
      bit         s;
      int         m;
      if (hi != 4'd0 && lo != 4'd0) begin s = 1'b0; m = 0; run++; end
      else if (lo != 4'd0)          begin s = 1'b1; m = int'(lo); end
      else                          begin s = 1'b0; m = int'(hi); end
      exp_bits.push_back(s);
      exp_cnt.push_back(run);
      for (int k = 3; k >= 0; k--) begin
        exp_bits.push_back(m[k]);
        exp_cnt.push_back(run);
      end
    end
    obs_bits.delete();
    set_start(sel, 1'b0);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    for (int j = 1; j <= 5*n + 4; j++) begin
      @(negedge clk);
      e_busy  = (j <= 2 + 5*n);
      e_sclk  = (j >= 2 && j <= 1 + 5*n);
      e_sdata = e_sclk ? exp_bits[j-2] : 1'b0;
      e_latch = (j == 2 + 5*n);
      e_done  = (j >= 3 + 5*n);
      e_cnt   = (j == 1) ? 0 : (j <= 1 + 5*n) ? exp_cnt[j-2] : run;
      exp = {e_busy, e_sclk, e_sdata, e_latch, e_done, e_cnt != 0, 6'(e_cnt)};
      obs = sel ? obs1 : obs0;
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s cycle %0d: {busy,sclk,sdata,latch,done,err,cnt} got %h want %h", tag, j, obs, exp);
      end
      if (obs[10]) obs_bits.push_back(obs[9]);
      last_cnt = obs[5:0];
      last_err = obs[6];
      if (toggle_mid && j == 10) set_start(sel, 1'b0);
      if (toggle_mid && j == 20) set_start(sel, 1'b1);
      if (toggle_mid && j == 30) set_start(sel, 1'b0);
      if (toggle_mid && j == 35) set_start(sel, 1'b1);
      if (change_mid && j == 40) for (int c = 16; c < 32; c++) cal_b[c] = rnd_byte();
    end
    set_start(sel, 1'b0);
  endtask

  task automatic check5(input string tag, input logic [4:0] got, input logic [4:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %b want %b", tag, got, want);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) cal_b[i] = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    assert ({obs0, obs1} === 24'h000000) else begin
      errors++; $error("FAIL reset_state got %h want 000000", {obs0, obs1});
    end
    rst = 1'b0;
    @(negedge clk);

    load("zeros", 1'b0, 16, 31, 1'b0, 1'b0);

    cal_b[31] = 8'h30;
    cal_b[16] = 8'h05;
    load("edge_words", 1'b0, 16, 31, 1'b0, 1'b0);
    check5("first_word", slot(0), 5'b00011);
    check5("last_word", slot(75), 5'b10101);

    for (int i = 0; i < 32; i++) cal_b[i] = 8'h0F;
    cal_b[20] = 8'h23;
    cal_b[25] = 8'h23;
    load("invalid_mix", 1'b0, 16, 31, 1'b0, 1'b0);
    check5("err_cnt_done", {last_err, last_cnt[3:0]}, 5'b10010);
    check5("slot_cmp25", slot(30), 5'b00000);
    check5("slot_cmp20", slot(55), 5'b00000);
    check5("slot_cmp31", slot(0), 5'b11111);
    check5("slot_cmp16", slot(75), 5'b11111);

    for (int i = 0; i < 32; i++) cal_b[i] = rnd_byte();
    load("mid_toggle_change", 1'b0, 16, 31, 1'b1, 1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) cal_b[i] = rnd_byte();
      load("random", 1'b0, 16, 31, 1'b0, 1'b0);
    end

    for (int i = 0; i < 32; i++) cal_b[i] = rnd_byte();
    start0 = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    repeat (41) @(negedge clk);
    checks++;
    assert (sclk0 === 1'b1) else begin
      errors++; $error("FAIL shift_cycle_40 sclk got %b want 1", sclk0);
    end
    rst = 1'b1;
    start0 = 1'b0;
    for (int j = 0; j < 90; j++) begin
      @(negedge clk);
      if (j == 3) rst = 1'b0;
      checks++;
      assert (obs0 === 12'h000) else begin
        errors++; $error("FAIL reset_abort cycle %0d got %h want 000", j, obs0);
      end
    end

    for (int i = 0; i < 32; i++) cal_b[i] = rnd_byte();
    load("after_reset", 1'b0, 16, 31, 1'b0, 1'b0);

    load("n1_first", 1'b1, 31, 31, 1'b0, 1'b0);
    cal_b[31] = 8'h4C;
    load("n1_back_to_back", 1'b1, 31, 31, 1'b0, 1'b0);
    cal_b[31] = 8'h0F;
    load("n1_negative", 1'b1, 31, 31, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_cal_trim_loader.md
Name: flash_cal_trim_loader

Overview:
- Consumer of the per-comparator calibration bytes produced by the flash ADC controller on cal_bot/cal_top.
- On each rising edge of the controller ready flag it snapshots the 256-bit calibration bus and decodes each selected comparator's 8-bit offset byte into a sign-magnitude trim word.
- It shifts the trim words serially into the analog comparator trim chain, then pulses the chain latch.
- It sits between the digital calibration controller and the comparator-bank trim registers.

Parameters:
- FIRST, 16, lowest comparator index loaded (0..31).
- LAST, 31, highest comparator index loaded (FIRST..31).
- TRIM_BITS, 5, trim word width: sign bit plus 4-bit magnitude. Fixed at 5; any other value is illegal.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level input driven by the controller rdy output; its rising edge requests a load.
- cal_bot  in  128  calibration bytes for comparators 0..15; byte i is cal_bot[8i+7:8i].
- cal_top  in  128  calibration bytes for comparators 16..31; byte i is cal_top[8(i-16)+7:8(i-16)].
- trim_sclk_en  out  1  shift-enable strobe; trim_sdata is valid in every cycle where this is 1.
- trim_sdata  out  1  serial trim data.
- trim_latch  out  1  one-cycle pulse that transfers the trim chain to the comparators.
- busy  out  1  load sequence in progress.
- done  out  1  last load completed.
- err  out  1  at least one invalid byte was seen in the last snapshot.
- err_cnt  out  6  number of invalid bytes in the last snapshot.

Behaviour:
- Reset: state IDLE; all outputs 0; snapshot register 0; start_d register 0.
  - Reset asserted mid-sequence aborts immediately.
  - No latch pulse is issued; the chain contents are undefined.
- Start detection:
  - start_d is a registered copy of start.
  - A request is start=1 and start_d=0, sampled in IDLE or DONE.
  - Requests seen in CAPTURE, SHIFT or LATCH are ignored; start_d still tracks start.
- Byte decode, with hi=b[7:4] and lo=b[3:0]:
  - hi=0, lo=0: sign 0, mag 0.
  - hi!=0, lo=0: sign 0, mag hi.
  - hi=0, lo!=0: sign 1, mag lo.
  - hi!=0, lo!=0: invalid. Emit sign 0, mag 0; count it in err_cnt.
  - mag 15 (saturated search) passes through unchanged.
- FSM states: IDLE, CAPTURE, SHIFT, LATCH, DONE.
  - IDLE/DONE -> CAPTURE on request.
    - done clears and busy sets in the same cycle.
    - err and err_cnt clear.
  - CAPTURE, 1 cycle: snapshot {cal_top, cal_bot}; busy=1.
  - SHIFT, N*5 cycles, where N=LAST-FIRST+1:
    - trim_sclk_en=1 every cycle.
    - Comparator order is LAST down to FIRST; within each word the order is sign, mag[3], mag[2], mag[1], mag[0].
    - err_cnt increments in the cycle where an invalid word's sign bit is shifted.
    - err = (err_cnt != 0), registered together with err_cnt.
  - LATCH, 1 cycle: trim_latch=1, trim_sclk_en=0.
  - DONE: busy=0, done=1. done holds until the next request or reset; err and err_cnt also hold.
- Timing: request sampled at edge k gives:
  - busy high from k+1;
  - first sclk_en at k+2;
  - last sclk_en at k+1+5N;
  - trim_latch at k+2+5N;
  - done at k+3+5N.
  - Defaults give 80 shift cycles, latch at k+82, done at k+83.
- Outputs are registered. trim_sdata=0 whenever trim_sclk_en=0.
- Input changes on cal_bot/cal_top after CAPTURE have no effect on the ongoing load.
- Counters: a 5-bit comparator index and a 3-bit bit index, both down-counting. The comparator index wraps only via the FSM exit; it never underflows below FIRST.

Decomposition:
- Package flash_cal_pkg holds:
  - NUM_CMP=32, CAL_BYTE_W=8, TRIM_BITS=5, HALF_W=128;
  - the FSM state enum;
  - a trim-word struct {sign, mag[3:0]}.
- Sub-module flash_cal_byte_decode is combinational: input 8-bit byte; outputs a 5-bit trim word and an invalid flag. It is instanced once on the muxed current byte.

Test Plan:
- Reset, then all bytes 0x00 with a start rise: busy at k+1, 80 sclk_en cycles with sdata=0, latch at k+82, done at k+83, err=0, err_cnt=0.
- Comparator 31 byte 0x30, comparator 16 byte 0x05, others 0: first 5 shifted bits 0,0,0,1,1; last 5 bits 1,0,1,0,1.
- Bytes for comparators 20 and 25 set to 0x23, others 0x0F: err=1, err_cnt=2 at done, invalid slots shift 00000, valid slots shift 11111.
- Toggle start high/low during SHIFT, and change cal_top mid-shift: no restart, shifted data equals the snapshot, and exactly one latch pulse.
- Assert rst at shift cycle 40: all outputs 0 next edge, no latch. A fresh start after release completes a full 80-cycle load.
- FIRST=LAST=31 (N=1): exactly 5 sclk_en cycles, latch at k+7, done at k+8. Back-to-back start rise in DONE re-runs the load and clears done at capture.
